// File: rtl/carwash_timers.sv
// Carwash spray and soap/rinse timers sharing one free-running tick prescaler.
// Each timer is armed by its clear input, counts ticks while enabled and latches done.

module cw_timer #(
    parameter int unsigned TICKS = 30
) (
    input  logic       clk,
    input  logic       CLR,
    input  logic       clr,
    input  logic       en,
    input  logic       tick,
    output logic       done,
    output logic [7:0] remain
);

    localparam int unsigned RW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] remain_n;
    logic          done_n;

    // State and registered outputs; reset discards all progress.
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state  <= IDLE;
            remain <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            remain <= remain_n;
            done   <= done_n;
        end
    end

    // Clear/arm wins over any tick; DONE holds at zero without underflow.
    always_comb begin
        state_n  = state;
        remain_n = remain;
        done_n   = done;
        if (clr) begin
            state_n  = RUN;
            remain_n = RW'(TICKS);
            done_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    remain_n = '0;
                    done_n   = 1'b0;
                end
                RUN: begin
                    if (tick && en) begin
                        remain_n = remain - RW'(1);
                        if (remain == RW'(1)) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    remain_n = '0;
                    done_n   = 1'b1;
                end
                default: begin
                    state_n  = IDLE;
                    remain_n = '0;
                    done_n   = 1'b0;
                end
            endcase
        end
    end

endmodule

module carwash_timers #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned T1_TICKS = 30,
    parameter int unsigned T2_TICKS = 20
) (
    input  logic       clk,
    input  logic       CLR,
    input  logic       CLRT1,
    input  logic       CLRT2,
    input  logic       SPRAY,
    input  logic       SOAP,
    output logic       T1DONE,
    output logic       T2DONE,
    output logic [7:0] T1_REMAIN,
    output logic [7:0] T2_REMAIN,
    output logic       TICK
);

    localparam int unsigned CW = 16;

    generate
        if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
            $error("carwash_timers: PRESCALE out of range 2..65535");
        end
        if (T1_TICKS < 1 || T1_TICKS > 255) begin : g_bad_t1
            $error("carwash_timers: T1_TICKS out of range 1..255");
        end
        if (T2_TICKS < 1 || T2_TICKS > 255) begin : g_bad_t2
            $error("carwash_timers: T2_TICKS out of range 1..255");
        end
    endgenerate

    logic [CW-1:0] pre_cnt, pre_cnt_n;

    always_comb begin
        pre_cnt_n = pre_cnt + CW'(1);
        if (pre_cnt == CW'(PRESCALE - 1)) begin
            pre_cnt_n = '0;
        end
    end

    // TICK is registered against the next count so it is high exactly while pre_cnt is at its top.
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            pre_cnt <= '0;
            TICK    <= 1'b0;
        end else begin
            pre_cnt <= pre_cnt_n;
            TICK    <= (pre_cnt_n == CW'(PRESCALE - 1));
        end
    end

    cw_timer #(.TICKS(T1_TICKS)) u_t1 (
        .clk    (clk),
        .CLR    (CLR),
        .clr    (CLRT1),
        .en     (SPRAY),
        .tick   (TICK),
        .done   (T1DONE),
        .remain (T1_REMAIN)
    );

    cw_timer #(.TICKS(T2_TICKS)) u_t2 (
        .clk    (clk),
        .CLR    (CLR),
        .clr    (CLRT2),
        .en     (SOAP),
        .tick   (TICK),
        .done   (T2DONE),
        .remain (T2_REMAIN)
    );

endmodule

// File: tb/tb_carwash_timers.sv
// Directed and randomized checks of carwash_timers against a tick-counting reference model.

module tb_carwash_timers;

    localparam int P  = 4;
    localparam int T1 = 3;
    localparam int T2 = 2;

    logic       clk = 1'b0;
    logic       CLR, CLRT1, CLRT2, SPRAY, SOAP;
    logic       T1DONE, T2DONE, TICK;
    logic [7:0] T1_REMAIN, T2_REMAIN;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase of the prescaler, and per timer whether armed and ticks left.
    int m_phase = 0;
    bit m_arm1 = 0, m_arm2 = 0;
    int m_rem1 = 0, m_rem2 = 0;

    carwash_timers #(.PRESCALE(P), .T1_TICKS(T1), .T2_TICKS(T2)) dut (
        .clk       (clk),
        .CLR       (CLR),
        .CLRT1     (CLRT1),
        .CLRT2     (CLRT2),
        .SPRAY     (SPRAY),
        .SOAP      (SOAP),
        .T1DONE    (T1DONE),
        .T2DONE    (T2DONE),
        .T1_REMAIN (T1_REMAIN),
        .T2_REMAIN (T2_REMAIN),
        .TICK      (TICK)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_arm1 = 0; m_arm2 = 0;
        m_rem1 = 0; m_rem2 = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".TICK"},      int'(TICK),      (m_phase == P-1) ? 1 : 0);
        chk({tag, ".T1_REMAIN"}, int'(T1_REMAIN), m_rem1);
        chk({tag, ".T2_REMAIN"}, int'(T2_REMAIN), m_rem2);
        chk({tag, ".T1DONE"},    int'(T1DONE),    (m_arm1 && m_rem1 == 0) ? 1 : 0);
        chk({tag, ".T2DONE"},    int'(T2DONE),    (m_arm2 && m_rem2 == 0) ? 1 : 0);
    endtask

    // One clock edge: advance the model from the inputs present at the edge, then compare.
    task automatic step(input string tag);
        bit tk;
        @(posedge clk);
        if (!CLR) begin
            model_reset();
        end else begin
            tk = (m_phase == P-1);
            m_phase = (m_phase + 1) % P;
            if (CLRT1) begin m_arm1 = 1; m_rem1 = T1; end
            else if (m_arm1 && tk && SPRAY && m_rem1 > 0) m_rem1--;
            if (CLRT2) begin m_arm2 = 1; m_rem2 = T2; end
            else if (m_arm2 && tk && SOAP && m_rem2 > 0) m_rem2--;
        end
        #1;
        check_all(tag);
    endtask

    // Steps with enable high until T1DONE, returning the number of ticks consumed.
    task automatic run_t1_to_done(input string tag, output int ticks);
        bit seen = 0;
        ticks = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (TICK) ticks++;
            step(tag);
            if (T1DONE) seen = 1;
        end
        chk({tag, ".done_within_bound"}, int'(seen), 1);
    endtask

    initial begin
        int ticks;
        int guard;
        CLR = 1'b0; CLRT1 = 1'b0; CLRT2 = 1'b0; SPRAY = 1'b0; SOAP = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        step("reset_hold");
        CLR = 1'b1;

        // Spray without arming: timer 1 must stay idle.
        SPRAY = 1'b1;
        for (int i = 0; i < 20; i++) step("idle_spray");
        chk("idle_remain", int'(T1_REMAIN), 0);
        chk("idle_done", int'(T1DONE), 0);

        // Arm, count down to done, then stay done for 10 more ticks.
        CLRT1 = 1'b1; step("arm1");
        chk("arm1_remain", int'(T1_REMAIN), T1);
        CLRT1 = 1'b0;
        run_t1_to_done("count1", ticks);
        chk("t1_latency_ticks", ticks, T1);
        chk("t1_remain_at_done", int'(T1_REMAIN), 0);
        for (int i = 0; i < 10 * P; i++) step("done_sticky");
        chk("sticky_done", int'(T1DONE), 1);

        // Clear coincident with a tick while in DONE.
        guard = 0;
        while (!TICK && guard < 2 * P) begin step("align_tick"); guard++; end
        chk("tick_aligned", int'(TICK), 1);
        CLRT1 = 1'b1; step("clr_on_tick");
        chk("clr_on_tick_remain", int'(T1_REMAIN), T1);
        chk("clr_on_tick_done", int'(T1DONE), 0);
        CLRT1 = 1'b0;

        // Pause after one tick, then resume.
        guard = 0;
        while (T1_REMAIN != 8'd2 && guard < 4 * P) begin step("to_two"); guard++; end
        SPRAY = 1'b0;
        for (int i = 0; i < 12; i++) step("paused");
        chk("pause_remain", int'(T1_REMAIN), 2);
        SPRAY = 1'b1;
        run_t1_to_done("resume", ticks);
        chk("resume_ticks", ticks, 2);

        // Both timers concurrently; held clear keeps timer 1 loaded.
        CLRT1 = 1'b1; CLRT2 = 1'b1; SOAP = 1'b1; step("arm_both");
        CLRT2 = 1'b0;
        for (int i = 0; i < 6 * P; i++) step("hold_clr1");
        chk("held_clr_remain", int'(T1_REMAIN), T1);
        chk("t2_done_indep", int'(T2DONE), 1);
        CLRT1 = 1'b0;

        // Async reset between edges while timer 2 has one tick left.
        CLRT2 = 1'b1; step("arm2");
        CLRT2 = 1'b0;
        guard = 0;
        while (T2_REMAIN != 8'd1 && guard < 4 * P) begin step("to_one"); guard++; end
        chk("t2_at_one", int'(T2_REMAIN), 1);
        @(negedge clk);
        CLR = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        step("reset_low");
        CLR = 1'b1;
        for (int i = 0; i < 12; i++) step("post_reset_idle");
        chk("t2_idle_after_reset", int'(T2_REMAIN), 0);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            CLRT1 = ($urandom_range(0, 15) == 0);
            CLRT2 = ($urandom_range(0, 15) == 0);
            SPRAY = ($urandom_range(0, 3) != 0);
            SOAP  = ($urandom_range(0, 3) != 0);
            if (CLR && $urandom_range(0, 299) == 0) begin
                CLR = 1'b0;
                model_reset();
                #1;
                check_all("rand_async");
            end else begin
                CLR = 1'b1;
            end
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/carwash_timers.md
CARWASH_TIMERS -- requirements
Module: carwash_timers

Interface
REQ-001 The block SHALL accept parameter PRESCALE, default 4, giving the clk cycles per timer tick, legal range 2..65535.
REQ-002 The block SHALL accept parameter T1_TICKS, default 30, giving the spray duration in ticks, legal range 1..255.
REQ-003 The block SHALL accept parameter T2_TICKS, default 20, giving the soap/rinse duration in ticks, legal range 1..255.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 CLR  input  1  reset, asynchronous, active-low.
REQ-006 CLRT1  input  1  synchronous clear/arm of timer 1, active high.
REQ-007 CLRT2  input  1  synchronous clear/arm of timer 2, active high.
REQ-008 SPRAY  input  1  timer 1 count enable, active high.
REQ-009 SOAP  input  1  timer 2 count enable, active high.
REQ-010 T1DONE  output  1  spray time expired; registered and sticky.
REQ-011 T2DONE  output  1  soap/rinse time expired; registered and sticky.
REQ-012 T1_REMAIN  output  8  remaining timer 1 ticks; registered.
REQ-013 T2_REMAIN  output  8  remaining timer 2 ticks; registered.
REQ-014 TICK  output  1  one-cycle prescaler strobe, exported for observation.

Function
REQ-015 The prescaler SHALL be a free-running counter 0..PRESCALE-1 that wraps to 0, with TICK=1 only in the cycle where it equals PRESCALE-1.
REQ-016 CLRT1/CLRT2 SHALL NOT affect the prescaler, so the first tick after arming arrives 1..PRESCALE cycles later.
REQ-017 Each timer SHALL implement states IDLE, RUN and DONE, independently of the other timer.
REQ-018 IDLE: remaining=0, done=0, and ticks are ignored regardless of the enable input.
REQ-019 In any state, CLRTn=1 at an edge SHALL load remaining=Tn_TICKS, drive TnDONE=0 and enter RUN.
REQ-020 CLRTn SHALL take priority over any simultaneous tick or enable.
REQ-021 RUN with TICK=1, enable=1 and no clear: remaining decrements by 1.
REQ-022 On the edge where remaining goes 1->0, the timer SHALL enter DONE and TnDONE SHALL go high on that same edge.
REQ-023 RUN with enable=0: remaining holds (pause) and the timer stays in RUN.
REQ-024 DONE: TnDONE stays 1 and remaining stays 0 until CLRTn or reset, with no underflow on further ticks.
REQ-025 CLRTn held high continuously SHALL keep the timer at Tn_TICKS with TnDONE=0.
REQ-026 Latency: with enable held high after arming, TnDONE SHALL rise on the edge of the Tn_TICKS-th tick after the arming edge.
REQ-027 Timer 1 and timer 2 SHALL run concurrently without interaction.
REQ-028 An out-of-range parameter SHALL stop elaboration with an error.

Reset
REQ-029 CLR=0 SHALL immediately, without waiting for clk, force both timers to IDLE, prescaler=0, T1DONE=T2DONE=0, T1_REMAIN=T2_REMAIN=0 and TICK=0.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard all progress, and the timers SHALL require CLRTn to re-arm.
REQ-031 Release of CLR SHALL take effect at the first clk edge after deassertion, with the prescaler starting from 0.

Verification (PRESCALE=4, T1_TICKS=3, T2_TICKS=2)
REQ-032 Reset, then SPRAY=1 for 20 cycles with no clear -> T1_REMAIN=0 and T1DONE=0 throughout.
REQ-033 CLRT1 pulse, then SPRAY=1 -> T1_REMAIN 3,2,1,0 on successive ticks; T1DONE rises on the 3rd-tick edge and stays 1 for 10 more ticks.
REQ-034 Arm T1, one tick elapses, SPRAY=0 for 12 cycles -> T1_REMAIN holds 2; SPRAY=1 -> T1DONE rises 2 ticks later.
REQ-035 T1 in DONE, CLRT1 coincident with TICK -> next cycle T1_REMAIN=3, T1DONE=0.
REQ-036 Arm both timers, SPRAY=1 and SOAP=1 -> T2DONE rises at tick 2 and T1DONE at tick 3, each independent of the other's clear.
REQ-037 CLR driven low between clk edges while T2_REMAIN=1 -> outputs reach reset values before the next edge; after release, T2 stays IDLE until CLRT2.
